// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared definitions for the five-stage pipeline hazard logic.
//               Holds the forwarding-select encodings, the hazard controller
//               state encoding and the register address width.
// Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

   // Register file address width.
   localparam int REG_AW = 5;

   // EX operand source selects.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Hazard controller state.
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } hz_state_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Combinational operand forwarding select for one EX-stage
//               ALU input. MEM has priority over WB; register 0 is never
//               forwarded.
// Revision    : 1.0  initial release
// Ports       : i_addr          - operand register address held in EX
//               i_mem_rd        - MEM stage destination register
//               i_mem_reg_write - MEM stage writes a register
//               i_wb_rd         - WB stage destination register
//               i_wb_reg_write  - WB stage writes a register
//               o_sel           - 00 = regfile, 01 = MEM, 10 = WB
// ============================================================================
module fwd_unit #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_addr,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_reg_write,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_reg_write,
   output logic [1:0]        o_sel
);
   import pipeline_pkg::*;

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_reg_write & (i_mem_rd != '0) & (i_mem_rd == i_addr);
   assign w_wb_hit  = i_wb_reg_write  & (i_wb_rd  != '0) & (i_wb_rd  == i_addr);

   always_comb begin
      o_sel = FWD_RF;
      if (w_mem_hit) begin
         o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
         o_sel = FWD_WB;
      end
   end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Central hazard controller for the five-stage pipeline.
//               Generates stall / flush / bubble controls for IF/ID and
//               ID/EX, EX operand forwarding selects, and sequences the
//               multi-cycle multiply/divide unit with a busy down-counter.
// Revision    : 1.0  initial release
// Options     : HAZARD_CTRL_PERF_EN - adds o_stall_cycles / o_flush_cycles
//               32-bit wrapping event counters.
// Ports       : clk, rst_n (async, active low)
//               i_id_*        - ID instruction operands and class
//               i_ex_*/i_mem_*/i_wb_* - downstream destination registers
//               i_ex_branch_taken - taken branch/jump resolved in EX
//               o_stall_if, o_stall_id, o_flush_id, o_bubble_ex - pipe ctl
//               o_fwd_a_sel, o_fwd_b_sel - EX operand sources
//               o_mdu_busy    - MDU occupied
// ============================================================================
module hazard_ctrl #(
   parameter int REG_AW      = pipeline_pkg::REG_AW,
   parameter int MDU_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_uses_rs,
   input  logic              i_id_uses_rt,
   input  logic              i_id_is_mdu,
   input  logic              i_id_uses_hilo,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_ex_reg_write,
   input  logic              i_ex_mem_read,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_reg_write,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_reg_write,
   input  logic              i_ex_branch_taken,
`ifdef HAZARD_CTRL_PERF_EN
   output logic [31:0]       o_stall_cycles,
   output logic [31:0]       o_flush_cycles,
`endif
   output logic              o_stall_if,
   output logic              o_stall_id,
   output logic              o_flush_id,
   output logic              o_bubble_ex,
   output logic [1:0]        o_fwd_a_sel,
   output logic [1:0]        o_fwd_b_sel,
   output logic              o_mdu_busy
);
   import pipeline_pkg::*;

   localparam logic [3:0] c_mdu_cnt_init = 4'(MDU_LATENCY - 1);

   hz_state_e         r_st;
   logic [3:0]        r_cnt;
   logic [REG_AW-1:0] r_ex_rs;
   logic [REG_AW-1:0] r_ex_rt;

   logic              w_load_use;
   logic              w_mdu_hold;
   logic              w_hold;
   logic              w_stall;
   logic              w_bubble;
   logic              w_mdu_issue;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;

   // ---------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------
   assign w_load_use = i_ex_mem_read & i_ex_reg_write & (i_ex_rd != '0) &
                       ((i_id_uses_rs & (i_ex_rd == i_id_rs)) |
                        (i_id_uses_rt & (i_ex_rd == i_id_rt)));

   assign w_mdu_hold = (r_st == MDU_BUSY) & (i_id_is_mdu | i_id_uses_hilo);
   assign w_hold     = w_load_use | w_mdu_hold;

   // A taken branch wins over any hold: the held instruction is on the
   // wrong path, so the front end must move on to fetch the target.
   assign w_stall    = w_hold & ~i_ex_branch_taken;
   assign w_bubble   = w_hold | i_ex_branch_taken;

   assign w_mdu_issue = (r_st == RUN) & i_id_is_mdu & ~w_hold & ~i_ex_branch_taken;

   // ---------------------------------------------------------------------
   // MDU sequencer. The cnt == 0 cycle is still busy; the branch input is
   // deliberately ignored here because the MDU op predates the branch.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st  <= RUN;
         r_cnt <= 4'd0;
      end else begin
         case (r_st)
            RUN: begin
               if (w_mdu_issue) begin
                  r_st  <= MDU_BUSY;
                  r_cnt <= c_mdu_cnt_init;
               end
            end
            MDU_BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_st <= RUN;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // ID/EX copy of the source addresses used for forwarding.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_rs <= '0;
         r_ex_rt <= '0;
      end else if (w_bubble) begin
         r_ex_rs <= '0;
         r_ex_rt <= '0;
      end else if (!w_stall) begin
         r_ex_rs <= i_id_rs;
         r_ex_rt <= i_id_rt;
      end
   end

   // ---------------------------------------------------------------------
   // Forwarding
   // ---------------------------------------------------------------------
   fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .i_addr          (r_ex_rs),
      .i_mem_rd        (i_mem_rd),
      .i_mem_reg_write (i_mem_reg_write),
      .i_wb_rd         (i_wb_rd),
      .i_wb_reg_write  (i_wb_reg_write),
      .o_sel           (w_fwd_a)
   );

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .i_addr          (r_ex_rt),
      .i_mem_rd        (i_mem_rd),
      .i_mem_reg_write (i_mem_reg_write),
      .i_wb_rd         (i_wb_rd),
      .i_wb_reg_write  (i_wb_reg_write),
      .o_sel           (w_fwd_b)
   );

   // ---------------------------------------------------------------------
   // Outputs are held inactive for as long as reset is asserted.
   // ---------------------------------------------------------------------
   assign o_stall_if  = rst_n & w_stall;
   assign o_stall_id  = rst_n & w_stall;
   assign o_flush_id  = rst_n & i_ex_branch_taken;
   assign o_bubble_ex = rst_n & w_bubble;
   assign o_fwd_a_sel = rst_n ? w_fwd_a : FWD_RF;
   assign o_fwd_b_sel = rst_n ? w_fwd_b : FWD_RF;
   assign o_mdu_busy  = rst_n & (r_st == MDU_BUSY);

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_cycles;

   // Free-running event counters; natural 32-bit wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= 32'd0;
         r_flush_cycles <= 32'd0;
      end else begin
         if (o_stall_if) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (o_flush_id) begin
            r_flush_cycles <= r_flush_cycles + 32'd1;
         end
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_cycles = r_flush_cycles;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MDU_LATENCY=4).
//               Inputs change 1 ns after the rising edge; outputs are
//               sampled a further 1 ns later.
// Revision    : 1.0  initial release
// Options     : HAZARD_CTRL_PERF_EN - also checks the event counters.
// ============================================================================
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic       id_uses_rs, id_uses_rt, id_is_mdu, id_uses_hilo;
   logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
   logic       ex_branch_taken;
   logic       stall_if, stall_id, flush_id, bubble_ex, mdu_busy;
   logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(5), .MDU_LATENCY(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_id_rs           (id_rs),
      .i_id_rt           (id_rt),
      .i_id_uses_rs      (id_uses_rs),
      .i_id_uses_rt      (id_uses_rt),
      .i_id_is_mdu       (id_is_mdu),
      .i_id_uses_hilo    (id_uses_hilo),
      .i_ex_rd           (ex_rd),
      .i_ex_reg_write    (ex_reg_write),
      .i_ex_mem_read     (ex_mem_read),
      .i_mem_rd          (mem_rd),
      .i_mem_reg_write   (mem_reg_write),
      .i_wb_rd           (wb_rd),
      .i_wb_reg_write    (wb_reg_write),
      .i_ex_branch_taken (ex_branch_taken),
`ifdef HAZARD_CTRL_PERF_EN
      .o_stall_cycles    (stall_cycles),
      .o_flush_cycles    (flush_cycles),
`endif
      .o_stall_if        (stall_if),
      .o_stall_id        (stall_id),
      .o_flush_id        (flush_id),
      .o_bubble_ex       (bubble_ex),
      .o_fwd_a_sel       (fwd_a_sel),
      .o_fwd_b_sel       (fwd_b_sel),
      .o_mdu_busy        (mdu_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_is_mdu = 0; id_uses_hilo = 0;
      ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
      mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
      ex_branch_taken = 0;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
      id_rs = 5; id_uses_rs = 1;
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      // Reset: outputs forced low even with hazards on the inputs.
      set_load_use();
      ex_branch_taken = 1;
      #12;
      check("rst_stall_if", {31'd0, stall_if}, 0);
      check("rst_flush_id", {31'd0, flush_id}, 0);
      check("rst_bubble_ex", {31'd0, bubble_ex}, 0);
      check("rst_mdu_busy", {31'd0, mdu_busy}, 0);
      clear_inputs();
      rst_n = 1;
      tick();
      check("idle_fwd_a", {30'd0, fwd_a_sel}, 0);
      check("idle_mdu_busy", {31'd0, mdu_busy}, 0);

      // Load-use: one stall cycle, then WB forwarding covers the load.
      set_load_use();
      #1;
      check("lu_stall_if", {31'd0, stall_if}, 1);
      check("lu_stall_id", {31'd0, stall_id}, 1);
      check("lu_bubble_ex", {31'd0, bubble_ex}, 1);
      check("lu_flush_id", {31'd0, flush_id}, 0);
      tick();
      ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
      mem_rd = 5; mem_reg_write = 1;
      #1;
      check("lu_next_stall", {31'd0, stall_if}, 0);
      check("lu_bubbled_fwd_a", {30'd0, fwd_a_sel}, 0);
      tick();
      mem_rd = 0; mem_reg_write = 0;
      wb_rd = 5; wb_reg_write = 1;
      #1;
      check("lu_fwd_a_wb", {30'd0, fwd_a_sel}, 2'b10);
      check("lu_after_stall", {31'd0, stall_if}, 0);

      // Forwarding priority and register 0.
      clear_inputs();
      id_rs = 3; id_rt = 7;
      tick();
      mem_rd = 7; mem_reg_write = 1; wb_rd = 7; wb_reg_write = 1;
      #1;
      check("fwd_b_mem_over_wb", {30'd0, fwd_b_sel}, 2'b01);
      check("fwd_a_no_match", {30'd0, fwd_a_sel}, 2'b00);
      mem_reg_write = 0;
      #1;
      check("fwd_b_wb", {30'd0, fwd_b_sel}, 2'b10);
      mem_rd = 3; mem_reg_write = 1;
      #1;
      check("fwd_a_mem", {30'd0, fwd_a_sel}, 2'b01);
      id_rt = 0;
      tick();
      mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
      #1;
      check("fwd_b_r0", {30'd0, fwd_b_sel}, 2'b00);

      // MDU issue then mfhi held for cycles 1-4, issues at cycle 5.
      clear_inputs();
      id_is_mdu = 1;
      #1;
      check("mdu_c0_busy", {31'd0, mdu_busy}, 0);
      check("mdu_c0_stall", {31'd0, stall_if}, 0);
      tick();
      id_is_mdu = 0; id_uses_hilo = 1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         check($sformatf("mdu_c%0d_busy", c), {31'd0, mdu_busy}, 1);
         check($sformatf("mdu_c%0d_stall", c), {31'd0, stall_if}, 1);
         tick();
      end
      check("mdu_c5_busy", {31'd0, mdu_busy}, 0);
      check("mdu_c5_stall", {31'd0, stall_if}, 0);
      tick();
      id_uses_hilo = 0;
      #1;
      check("mdu_mfhi_no_reissue", {31'd0, mdu_busy}, 0);

      // Back-to-back MDU with a taken branch during busy.
      id_is_mdu = 1;
      tick();                                   // cycle 1
      check("b2b_c1_stall", {31'd0, stall_if}, 1);
      tick();                                   // cycle 2
      ex_branch_taken = 1;
      #1;
      check("b2b_br_flush", {31'd0, flush_id}, 1);
      check("b2b_br_stall", {31'd0, stall_if}, 0);
      check("b2b_br_busy", {31'd0, mdu_busy}, 1);
      tick();                                   // cycle 3
      ex_branch_taken = 0;
      #1;
      check("b2b_c3_busy", {31'd0, mdu_busy}, 1);
      tick();                                   // cycle 4, cnt == 0
      check("b2b_c4_busy", {31'd0, mdu_busy}, 1);
      check("b2b_c4_stall", {31'd0, stall_if}, 1);
      tick();                                   // cycle 5, RUN, issue
      check("b2b_c5_busy", {31'd0, mdu_busy}, 0);
      check("b2b_c5_stall", {31'd0, stall_if}, 0);
      tick();                                   // cycle 6
      id_is_mdu = 0;
      #1;
      check("b2b_c6_busy", {31'd0, mdu_busy}, 1);
      repeat (4) tick();
      check("b2b_drained", {31'd0, mdu_busy}, 0);

      // Branch beats load-use.
      set_load_use();
      ex_branch_taken = 1;
      #1;
      check("brlu_flush", {31'd0, flush_id}, 1);
      check("brlu_bubble", {31'd0, bubble_ex}, 1);
      check("brlu_stall_if", {31'd0, stall_if}, 0);
      check("brlu_stall_id", {31'd0, stall_id}, 0);
      tick();
      clear_inputs();

      // Asynchronous reset in MDU_BUSY with cnt == 2.
      id_is_mdu = 1;
      tick();
      id_is_mdu = 0; id_uses_hilo = 1;
      tick();
      check("arst_pre_busy", {31'd0, mdu_busy}, 1);
      check("arst_pre_stall", {31'd0, stall_if}, 1);
      #1 rst_n = 0;
      #1;
      check("arst_busy", {31'd0, mdu_busy}, 0);
      check("arst_stall", {31'd0, stall_if}, 0);
      check("arst_bubble", {31'd0, bubble_ex}, 0);
      #1 rst_n = 1;
      #1;
      check("arst_rel_busy", {31'd0, mdu_busy}, 0);
      check("arst_rel_stall", {31'd0, stall_if}, 0);
      tick();
      check("arst_run_busy", {31'd0, mdu_busy}, 0);
      clear_inputs();

`ifdef HAZARD_CTRL_PERF_EN
      repeat (3) begin
         set_load_use();
         tick();
         clear_inputs();
         tick();
      end
      repeat (2) begin
         ex_branch_taken = 1;
         tick();
         ex_branch_taken = 0;
         tick();
      end
      check("perf_stall_cycles", stall_cycles, 3);
      check("perf_flush_cycles", flush_cycles, 2);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the five-stage pipeline. It watches the ID operand addresses and the destination registers of the EX, MEM and WB stages.
- Each cycle it produces stall, flush and bubble controls for the IF/ID and ID/EX pipeline registers, plus operand forwarding selects for the EX-stage ALU inputs.
- It also sequences the multi-cycle multiply/divide unit (MDU) with a busy counter, holding dependent instructions in ID until the unit finishes.

Parameters:
- REG_AW, 5, register address width.
- MDU_LATENCY, 4, cycles the MDU is busy after an issue; legal range 2..15.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- id_rs, input, REG_AW, source register A address of the instruction in ID.
- id_rt, input, REG_AW, source register B address of the instruction in ID.
- id_uses_rs, input, 1, the ID instruction reads rs.
- id_uses_rt, input, 1, the ID instruction reads rt.
- id_is_mdu, input, 1, the ID instruction is a mult/div.
- id_uses_hilo, input, 1, the ID instruction reads HI/LO (mfhi/mflo).
- ex_rd, input, REG_AW, destination register of the instruction in EX.
- ex_reg_write, input, 1, the EX instruction writes a register.
- ex_mem_read, input, 1, the EX instruction is a load.
- mem_rd, input, REG_AW, destination register of the instruction in MEM.
- mem_reg_write, input, 1, the MEM instruction writes a register.
- wb_rd, input, REG_AW, destination register of the instruction in WB.
- wb_reg_write, input, 1, the WB instruction writes a register.
- ex_branch_taken, input, 1, a branch or jump resolved taken in EX this cycle.
- stall_if, output, 1, hold the PC and the IF/ID register.
- stall_id, output, 1, hold the ID stage (no advance into ID/EX).
- flush_id, output, 1, clear the IF/ID register to a NOP.
- bubble_ex, output, 1, load a NOP into the ID/EX register.
- fwd_a_sel, output, 2, EX operand A source: 00 = register file, 01 = MEM result, 10 = WB result.
- fwd_b_sel, output, 2, EX operand B source; same encoding as fwd_a_sel.
- mdu_busy, output, 1, high while the MDU is occupied.

Behaviour:
- State register: st in {RUN, MDU_BUSY}. Down-counter: cnt, 4 bits.
- Reset (reset = 0, asynchronous): st = RUN, cnt = 0. While reset is low, force all outputs to 0 (fwd selects = 00).
- Forwarding is combinational, zero latency, evaluated independently for A (against ex-stage rs) and B (against ex-stage rt). The ID/EX register stage carries ex_rs/ex_rt internally: they are registered from id_rs/id_rt when ID advances, and cleared to 0 on a bubble.
  - Select 01 if mem_reg_write, mem_rd != 0 and mem_rd equals the operand address.
  - Otherwise select 10 if wb_reg_write, wb_rd != 0 and wb_rd equals the operand address.
  - Otherwise select 00. MEM always beats WB. Register 0 is never forwarded.
- load_use = ex_mem_read & ex_reg_write & (ex_rd != 0) & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- mdu_hold = (st == MDU_BUSY) & (id_is_mdu | id_uses_hilo).
- hold = load_use | mdu_hold. Combinational result: stall_if = stall_id = bubble_ex = hold.
- Branch taken in EX: flush_id = 1 and bubble_ex = 1. stall_if and stall_id are forced to 0, so the branch target is fetched. The branch has priority over hold because the held instruction is on the wrong path.
- MDU issue: when st == RUN, id_is_mdu = 1, hold = 0 and ex_branch_taken = 0, then on the next edge st moves to MDU_BUSY and cnt = MDU_LATENCY - 1.
- In MDU_BUSY: cnt decrements by 1 each cycle. When cnt == 0, the next edge returns st to RUN. The cnt == 0 cycle still counts as busy.
- mdu_busy = (st == MDU_BUSY).
- A taken branch during MDU_BUSY does not cancel the count, because the MDU operation is older than the branch.
- An MDU op arriving in ID while busy is held until RUN, then issues on the first RUN cycle (back-to-back issue allowed with no gap cycle).
- Load-use stall always lasts exactly 1 cycle. On the next cycle the load is in MEM and forwarding select 10 covers it at WB timing. The stall repeats only if a new hazard appears.
- Reset mid-MDU: abandons the count immediately and returns to RUN.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments on every cycle with stall_if = 1; flush_cycles increments on every cycle with flush_id = 1.
  - Both wrap from 0xFFFFFFFF to 0 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - the hazard state enum {RUN, MDU_BUSY};
  - REG_AW.
- One natural sub-module: fwd_unit. It is purely combinational, instantiated twice (operand A and operand B), and maps one operand address to a 2-bit select.

Test Plan:
- ex_mem_read = 1, ex_rd = 5, id_rs = 5, id_uses_rs = 1 → stall_if = stall_id = bubble_ex = 1 for exactly 1 cycle; next cycle fwd_a_sel = 10 when wb_rd = 5.
- mem_rd = 7 and wb_rd = 7 both writing, ex-stage rt = 7 → fwd_b_sel = 01. Same with rd = 0 → fwd_b_sel = 00.
- MDU_LATENCY = 4, id_is_mdu pulse at cycle 0 → mdu_busy high for cycles 1–4. An mfhi in ID during cycles 1–4 sees stall_if = 1; it issues at cycle 5 with stall = 0.
- ex_branch_taken = 1 coinciding with load_use = 1 → flush_id = 1, bubble_ex = 1, stall_if = 0.
- Drive reset low during MDU_BUSY with cnt = 2 → mdu_busy = 0 and all outputs = 0 immediately (asynchronous). After release, st = RUN.
- With HAZARD_CTRL_PERF_EN: 3 load-use stalls and 2 flushes → stall_cycles = 3, flush_cycles = 2.
